// File: rtl/div_8x3_seq_pkg.sv
// Shared constants and FSM encoding for the sequential 8x3 signed divider.
package div_8x3_seq_pkg;

  localparam int unsigned DivDw = 8;
  localparam int unsigned DivVw = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StSign = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_8x3_seq_step.sv
// One restoring-division step: shift in the next dividend bit and try to subtract |divisor|.
module div_8x3_seq_step #(
  parameter int unsigned VW = 3
) (
  input  logic [VW:0]   part_i,
  input  logic          bit_i,
  input  logic [VW-1:0] dvs_i,
  output logic [VW:0]   part_o,
  output logic          qbit_o
);

  localparam int unsigned PW = VW + 1;

  logic [VW+1:0] shifted;
  logic [VW+1:0] dvs_ext;

  always_comb begin
    shifted = {part_i, bit_i};
    dvs_ext = {2'b00, dvs_i};
    qbit_o  = (shifted >= dvs_ext);
    // The partial stays below |divisor| <= 4, so the result always fits PW bits.
    part_o  = qbit_o ? PW'(shifted - dvs_ext) : PW'(shifted);
  end

endmodule

// File: rtl/div_8x3_seq.sv
// Sequential signed divider: restoring division on magnitudes, then sign fix-up.
module div_8x3_seq
  import div_8x3_seq_pkg::*;
#(
  parameter int unsigned DW = DivDw,
  parameter int unsigned VW = DivVw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic          overflow
);

  localparam int unsigned CW = $clog2(DW + 1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW:0]   part_q, part_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          div_by_zero_q, div_by_zero_d;
  logic          overflow_q, overflow_d;

  logic          accept;
  logic [VW:0]   step_part;
  logic          step_qbit;

  // The done cycle is IDLE but must not accept a new request.
  assign accept = (state_q == StIdle) && start && !done_q;

  div_8x3_seq_step #(
    .VW (VW)
  ) u_step (
    .part_i (part_q),
    .bit_i  (dvd_q[DW-1]),
    .dvs_i  (dvs_q),
    .part_o (step_part),
    .qbit_o (step_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      count_q       <= '0;
      dvd_q         <= '0;
      part_q        <= '0;
      dvs_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      dbz_q         <= 1'b0;
      ovf_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      dvd_q         <= dvd_d;
      part_q        <= part_d;
      dvs_q         <= dvs_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      dbz_q         <= dbz_d;
      ovf_q         <= ovf_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = (divisor == '0) ? StSign : StCalc;
      StCalc: if (count_q == CW'(1)) state_d = StSign;
      StSign: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d       = count_q;
    dvd_d         = dvd_q;
    part_d        = part_q;
    dvs_d         = dvs_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    dbz_d         = dbz_q;
    ovf_d         = ovf_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          dvd_d     = dividend[DW-1] ? -dividend : dividend;
          dvs_d     = divisor[VW-1] ? -divisor : divisor;
          part_d    = '0;
          count_d   = CW'(DW);
          neg_quo_d = dividend[DW-1] ^ divisor[VW-1];
          neg_rem_d = dividend[DW-1];
          dbz_d     = (divisor == '0);
          ovf_d     = (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);
          busy_d    = 1'b1;
        end
      end
      StCalc: begin
        dvd_d   = {dvd_q[DW-2:0], step_qbit};
        part_d  = step_part;
        count_d = count_q - CW'(1);
      end
      StSign: begin
        busy_d        = 1'b0;
        done_d        = 1'b1;
        div_by_zero_d = dbz_q;
        overflow_d    = ovf_q;
        if (dbz_q) begin
          quotient_d  = '0;
          remainder_d = '0;
        end else begin
          // A magnitude of 2^(DW-1) with positive sign wraps to -2^(DW-1).
          quotient_d  = neg_quo_q ? -dvd_q : dvd_q;
          remainder_d = neg_rem_q ? -part_q[VW-1:0] : part_q[VW-1:0];
        end
      end
      default: ;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule
